// File: rtl/menu_pkg.sv
// Shared definitions for the menu navigation block: keypad indices,
// text colours and the enums used by the auto-repeat logic.
package menu_pkg;
    localparam int KEY_UP    = 8;
    localparam int KEY_DOWN  = 2;
    localparam int KEY_LEFT  = 4;
    localparam int KEY_RIGHT = 6;

    localparam logic [7:0] COLOR_BLUE  = 8'h03;
    localparam logic [7:0] COLOR_WHITE = 8'hFF;

    typedef enum logic [1:0] {RPT_IDLE, RPT_HOLD, RPT_REPEAT} rpt_state_e;
    typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_e;
endpackage

// File: rtl/key_autorepeat.sv
// Key edge detection plus hold/repeat timing; emits one step strobe per
// movement together with the currently active direction.
module key_autorepeat
    import menu_pkg::*;
#(
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [3:0] keys,        // {right, left, down, up}
    input  logic       enter,
    input  logic       freeze,
    output logic       step,
    output dir_e       dir,
    output logic       enter_rise
);
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [3:0]       key_q;
    logic             enter_q;
    logic             armed;     // blocks edges on the first sample after reset
    rpt_state_e       state;
    dir_e             held_dir;
    logic [CNT_W-1:0] cnt;
    dir_e             act_dir;
    logic [3:0]       rise;
    logic             act_rise;
    logic             new_press;

    always_comb begin
        act_dir = DIR_NONE;
        if (keys[0] ^ keys[1])      act_dir = keys[0] ? DIR_UP : DIR_DOWN;
        else if (keys[2] ^ keys[3]) act_dir = keys[2] ? DIR_LEFT : DIR_RIGHT;
    end

    assign rise = keys & ~key_q & {4{armed}};

    always_comb begin
        act_rise = 1'b0;
        case (act_dir)
            DIR_UP:    act_rise = rise[0];
            DIR_DOWN:  act_rise = rise[1];
            DIR_LEFT:  act_rise = rise[2];
            DIR_RIGHT: act_rise = rise[3];
            default:   act_rise = 1'b0;
        endcase
    end

    always_comb begin
        new_press = 1'b0;
        step      = 1'b0;
        if (!freeze && act_dir != DIR_NONE) begin
            if (state == RPT_IDLE)      new_press = act_rise;
            else if (act_dir != held_dir) new_press = 1'b1;
            step = new_press || (state != RPT_IDLE && cnt == '0);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            key_q    <= '0;
            enter_q  <= 1'b0;
            armed    <= 1'b0;
            state    <= RPT_IDLE;
            held_dir <= DIR_NONE;
            cnt      <= '0;
        end else begin
            key_q   <= keys;
            enter_q <= enter;
            armed   <= 1'b1;
            if (freeze || act_dir == DIR_NONE) begin
                state <= RPT_IDLE;
                cnt   <= '0;
            end else if (new_press) begin
                state    <= RPT_HOLD;
                cnt      <= CNT_W'(REPEAT_DELAY - 1);
                held_dir <= act_dir;
            end else if (state != RPT_IDLE) begin
                if (cnt == '0) begin
                    state <= RPT_REPEAT;
                    cnt   <= CNT_W'(REPEAT_RATE - 1);
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    assign dir        = act_dir;
    assign enter_rise = enter & ~enter_q & armed;
endmodule

// File: rtl/menu_nav_controller.sv
// Menu cursor and per-item value selector driven by keypad steps; enter on
// the start line latches game_started and freezes the menu until reset.
module menu_nav_controller
    import menu_pkg::*;
#(
    parameter int N_ITEMS      = 4,
    parameter int N_VALS       = 4,
    parameter int WRAP         = 0,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000,
    parameter int START_IDX    = N_ITEMS - 1,
    localparam int IDX_W       = $clog2(N_ITEMS),
    localparam int VAL_W       = $clog2(N_VALS)
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic [N_ITEMS-1:0]       dr_title_arr,
    input  logic [9:0]               key_is_pressed,
    input  logic                     enter,
    output logic                     dr,
    output logic [7:0]               rgb,
    output logic [IDX_W-1:0]         hovered_idx,
    output logic [N_ITEMS*VAL_W-1:0] item_values,
    output logic                     value_changed,
    output logic                     game_started
);
    logic [N_ITEMS-1:0][VAL_W-1:0] vals;
    logic [VAL_W-1:0]              cur_val;
    logic                          step;
    logic                          enter_rise;
    dir_e                          dir;
    logic                          unused_keys;

    assign unused_keys = ^{key_is_pressed[9], key_is_pressed[7], key_is_pressed[5],
                           key_is_pressed[3], key_is_pressed[1], key_is_pressed[0]};

    key_autorepeat #(
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_rpt (
        .clk       (clk),
        .resetN    (resetN),
        .keys      ({key_is_pressed[KEY_RIGHT], key_is_pressed[KEY_LEFT],
                     key_is_pressed[KEY_DOWN],  key_is_pressed[KEY_UP]}),
        .enter     (enter),
        .freeze    (game_started),
        .step      (step),
        .dir       (dir),
        .enter_rise(enter_rise)
    );

    assign cur_val = vals[hovered_idx];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hovered_idx   <= '0;
            vals          <= '0;
            value_changed <= 1'b0;
            game_started  <= 1'b0;
        end else begin
            value_changed <= 1'b0;
            if (!game_started) begin
                // start is judged on the index before this cycle's move
                if (enter_rise && hovered_idx == IDX_W'(START_IDX)) game_started <= 1'b1;
                if (step) begin
                    case (dir)
                        DIR_UP:
                            if (hovered_idx != '0)   hovered_idx <= hovered_idx - 1'b1;
                            else if (WRAP != 0)      hovered_idx <= IDX_W'(N_ITEMS - 1);
                        DIR_DOWN:
                            if (hovered_idx != IDX_W'(N_ITEMS - 1)) hovered_idx <= hovered_idx + 1'b1;
                            else if (WRAP != 0)                     hovered_idx <= '0;
                        DIR_LEFT:
                            if (cur_val != '0) begin
                                vals[hovered_idx] <= cur_val - 1'b1;
                                value_changed     <= 1'b1;
                            end else if (WRAP != 0) begin
                                vals[hovered_idx] <= VAL_W'(N_VALS - 1);
                                value_changed     <= 1'b1;
                            end
                        DIR_RIGHT:
                            if (cur_val != VAL_W'(N_VALS - 1)) begin
                                vals[hovered_idx] <= cur_val + 1'b1;
                                value_changed     <= 1'b1;
                            end else if (WRAP != 0) begin
                                vals[hovered_idx] <= '0;
                                value_changed     <= 1'b1;
                            end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign item_values = vals;
    assign dr          = |dr_title_arr;
    assign rgb         = dr_title_arr[hovered_idx] ? COLOR_BLUE : COLOR_WHITE;
endmodule
